// File: rtl/mini_rv32i.sv
// mini_rv32i: single-cycle RV32I core with a fixed firmware ROM, a small word
// RAM and an MMIO window. The firmware reads A, B and OP from MMIO, computes
// the result in x3, stores it to OUT_RES and then stores to DONE, after which
// the core freezes until reset.
module mini_rv32i #(
  parameter int          IMEM_WORDS = 64,
  parameter int          DMEM_WORDS = 256,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_in_a,
  input  logic [31:0] io_in_b,
  input  logic [1:0]  io_op,
  output logic [31:0] io_out_res,
  output logic        io_out_valid,
  output logic [31:0] x3_out,
  output logic        done
);

  localparam int          IW        = $clog2(IMEM_WORDS);
  localparam int          DW        = $clog2(DMEM_WORDS);
  localparam logic [31:0] DMEM_BASE = 32'h0000_1000;
  localparam logic [31:0] DMEM_END  = DMEM_BASE + 32'(4 * DMEM_WORDS);
  localparam logic [31:0] NOP       = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Firmware. x4 = MMIO base, x5/x6/x7 = A/B/OP. x7 is decremented so that
  // op==1 selects SUB and op==3 selects XOR; anything else falls to ADD.
  function automatic logic [31:0] rom_word(input logic [IW-1:0] idx);
    case (int'(idx))
      0:       rom_word = 32'h1000_0237; // lui  x4, 0x10000
      1:       rom_word = 32'h0002_2283; // lw   x5, 0(x4)
      2:       rom_word = 32'h0042_2303; // lw   x6, 4(x4)
      3:       rom_word = 32'h0082_2383; // lw   x7, 8(x4)
      4:       rom_word = 32'h4062_81B3; // sub  x3, x5, x6
      5:       rom_word = 32'hFFF3_8393; // addi x7, x7, -1
      6:       rom_word = 32'h0003_8A63; // beq  x7, x0, +20 (-> store)
      7:       rom_word = 32'h0062_C1B3; // xor  x3, x5, x6
      8:       rom_word = 32'hFFE3_8393; // addi x7, x7, -2
      9:       rom_word = 32'h0003_8463; // beq  x7, x0, +8 (-> store)
      10:      rom_word = 32'h0062_81B3; // add  x3, x5, x6
      11:      rom_word = 32'h0032_2623; // sw   x3, 12(x4)  OUT_RES
      12:      rom_word = 32'h0002_2823; // sw   x0, 16(x4)  DONE
      13:      rom_word = 32'h0000_006F; // jal  x0, 0
      default: rom_word = NOP;
    endcase
  endfunction

  logic [31:0] pc;
  logic [31:0] regs [0:31];
  logic [31:0] dmem [0:DMEM_WORDS-1];

  logic [31:0] instr;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;

  logic [31:0] alu_b, alu_res;
  logic [4:0]  shamt;
  logic        alt_op;

  logic [31:0] mem_addr, word_addr, dmem_off;
  logic        mmio_hit, dmem_hit;
  logic [2:0]  mmio_off;
  logic [DW-1:0] dmem_idx;
  logic [31:0] load_data;

  logic [31:0] next_pc, wb_data;
  logic        wb_en, st_en;

  // Instruction fetch and field decode; addresses outside the ROM fetch a NOP.
  always_comb begin
    instr   = (pc[31:IW+2] == '0) ? rom_word(pc[IW+1:2]) : NOP;
    opcode  = instr[6:0];
    rd      = instr[11:7];
    funct3  = instr[14:12];
    rs1     = instr[19:15];
    rs2     = instr[24:20];
    funct7  = instr[31:25];
    imm_i   = {{20{instr[31]}}, instr[31:20]};
    imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    imm_b   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_u   = {instr[31:12], 12'b0};
    imm_j   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    rs1_val = regs[rs1];
    rs2_val = regs[rs2];
  end

  // Shared ALU for OP and OP-IMM; instr[30] selects SUB (OP only) and SRA/SRAI.
  always_comb begin
    alu_b  = (opcode == OPC_OP) ? rs2_val : imm_i;
    shamt  = alu_b[4:0];
    alt_op = instr[30];
    alu_res = '0;
    case (funct3)
      3'b000: alu_res = (opcode == OPC_OP && alt_op) ? rs1_val - alu_b : rs1_val + alu_b;
      3'b001: alu_res = rs1_val << shamt;
      3'b010: alu_res = {31'b0, $signed(rs1_val) < $signed(alu_b)};
      3'b011: alu_res = {31'b0, rs1_val < alu_b};
      3'b100: alu_res = rs1_val ^ alu_b;
      3'b101: alu_res = alt_op ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
      3'b110: alu_res = rs1_val | alu_b;
      3'b111: alu_res = rs1_val & alu_b;
      default: alu_res = '0;
    endcase
  end

  // Address decode and combinational load path; low two address bits ignored.
  always_comb begin
    mem_addr  = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
    word_addr = {mem_addr[31:2], 2'b00};
    mmio_hit  = (word_addr[31:5] == MMIO_BASE[31:5]);
    mmio_off  = word_addr[4:2];
    dmem_hit  = (word_addr >= DMEM_BASE) && (word_addr < DMEM_END);
    dmem_off  = word_addr - DMEM_BASE;
    dmem_idx  = dmem_off[DW+1:2];
    load_data = '0;
    if (mmio_hit) begin
      case (mmio_off)
        3'd0:    load_data = io_in_a;
        3'd1:    load_data = io_in_b;
        3'd2:    load_data = {30'b0, io_op};
        3'd3:    load_data = io_out_res;
        3'd4:    load_data = {31'b0, done};
        default: load_data = '0;
      endcase
    end else if (dmem_hit) begin
      load_data = dmem[dmem_idx];
    end
  end

  // Control: next pc, writeback and store enable. Unsupported encodings
  // keep every default and therefore behave as a NOP.
  always_comb begin
    next_pc = pc + 32'd4;
    wb_en   = 1'b0;
    wb_data = '0;
    st_en   = 1'b0;
    case (opcode)
      OPC_LUI: begin
        wb_en = 1'b1; wb_data = imm_u;
      end
      OPC_AUIPC: begin
        wb_en = 1'b1; wb_data = pc + imm_u;
      end
      OPC_JAL: begin
        wb_en = 1'b1; wb_data = pc + 32'd4; next_pc = pc + imm_j;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          wb_en = 1'b1; wb_data = pc + 32'd4;
          next_pc = (rs1_val + imm_i) & ~32'd1;
        end
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000: if (rs1_val == rs2_val) next_pc = pc + imm_b;
          3'b001: if (rs1_val != rs2_val) next_pc = pc + imm_b;
          3'b100: if ($signed(rs1_val) <  $signed(rs2_val)) next_pc = pc + imm_b;
          3'b101: if ($signed(rs1_val) >= $signed(rs2_val)) next_pc = pc + imm_b;
          3'b110: if (rs1_val <  rs2_val) next_pc = pc + imm_b;
          3'b111: if (rs1_val >= rs2_val) next_pc = pc + imm_b;
          default: ;
        endcase
      end
      OPC_LOAD: begin
        if (funct3 == 3'b010) begin
          wb_en = 1'b1; wb_data = load_data;
        end
      end
      OPC_STORE: begin
        if (funct3 == 3'b010) st_en = 1'b1;
      end
      OPC_OPIMM: begin
        if ((funct3 == 3'b001 && funct7 != 7'b0000000) ||
            (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)) begin
          wb_en = 1'b0;
        end else begin
          wb_en = 1'b1; wb_data = alu_res;
        end
      end
      OPC_OP: begin
        if (funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          wb_en = 1'b1; wb_data = alu_res;
        end
      end
      default: ;
    endcase
  end

  // Architectural state update; once done is set nothing retires until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= '0;
      io_out_res   <= '0;
      io_out_valid <= 1'b0;
      done         <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (!done) begin
      pc <= next_pc;
      if (wb_en && rd != 5'd0) regs[rd] <= wb_data;
      if (st_en && mmio_hit) begin
        if (mmio_off == 3'd3) begin
          io_out_res   <= rs2_val;
          io_out_valid <= 1'b1;
        end
        if (mmio_off == 3'd4) done <= 1'b1;
      end
    end
  end

  // Data RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && !done && st_en && dmem_hit) dmem[dmem_idx] <= rs2_val;
  end

  assign x3_out = regs[3];

  logic unused_bits;
  assign unused_bits = ^{pc[1:0], mem_addr[1:0], dmem_off[31:DW+2], dmem_off[1:0]};

endmodule

// File: tb/tb_mini_rv32i.sv
// Directed bench for mini_rv32i: runs the firmware for hand-computed operand
// sets, checks reset values, result, ordering, latency, mid-program abort and
// post-done stability.
module tb_mini_rv32i;

  logic        clk;
  logic        rst;
  logic [31:0] io_in_a;
  logic [31:0] io_in_b;
  logic [1:0]  io_op;
  logic [31:0] io_out_res;
  logic        io_out_valid;
  logic [31:0] x3_out;
  logic        done;

  int checks   = 0;
  int failures = 0;

  mini_rv32i dut (
    .clk          (clk),
    .rst          (rst),
    .io_in_a      (io_in_a),
    .io_in_b      (io_in_b),
    .io_op        (io_op),
    .io_out_res   (io_out_res),
    .io_out_valid (io_out_valid),
    .x3_out       (x3_out),
    .done         (done)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hold reset for n edges, then release just after an edge.
  task automatic pulse_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_res"},   io_out_res,   32'h0);
    check({tag, "_valid"}, {31'b0, io_out_valid}, 32'h0);
    check({tag, "_done"},  {31'b0, done}, 32'h0);
    check({tag, "_x3"},    x3_out,       32'h0);
  endtask

  // Run from reset release until done (20-cycle budget) and check the outcome.
  task automatic run_prog(input string tag, input logic [31:0] exp);
    int   cyc;
    logic prev_valid;
    logic early_valid;
    cyc = 0;
    prev_valid = 1'b0;
    early_valid = 1'b0;
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done === 1'b1) early_valid = prev_valid;
      else prev_valid = io_out_valid;
    end
    check({tag, "_done_in_20"},  {31'b0, done},        32'h1);
    check({tag, "_valid_early"}, {31'b0, early_valid}, 32'h1);
    check({tag, "_valid"},       {31'b0, io_out_valid}, 32'h1);
    check({tag, "_res"},         io_out_res,           exp);
    check({tag, "_x3"},          x3_out,               exp);
  endtask

  task automatic set_inputs(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    io_in_a = a;
    io_in_b = b;
    io_op   = op;
  endtask

  initial begin
    rst = 1'b1;
    set_inputs(32'd21, 32'd9, 2'd0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("init");
    rst = 1'b0;
    run_prog("add_21_9", 32'd30);

    set_inputs(32'd9, 32'd21, 2'd1);
    pulse_reset(2);
    run_prog("sub_wrap", 32'hFFFF_FFF4);

    set_inputs(32'hFFFF_0000, 32'h0000_FFFF, 2'd0);
    pulse_reset(2);
    run_prog("add_ones", 32'hFFFF_FFFF);

    set_inputs(32'd5, 32'd7, 2'd2);
    pulse_reset(2);
    run_prog("op2_add", 32'd12);

    set_inputs(32'd5, 32'd7, 2'd3);
    pulse_reset(2);
    run_prog("op3_xor", 32'd2);

    set_inputs(32'h1234_5678, 32'h1234_5678, 2'd1);
    pulse_reset(2);
    run_prog("sub_zero", 32'h0);

    // Reset after a nonzero result: outputs must clear while rst is held.
    set_inputs(32'd100, 32'd1, 2'd0);
    pulse_reset(2);
    run_prog("pre_rst", 32'd101);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("in_rst");

    // Abort mid-program at cycle 3, change operands, rerun.
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_not_done", {31'b0, done}, 32'h0);
    set_inputs(32'd40, 32'd2, 2'd1);
    pulse_reset(1);
    run_prog("after_abort", 32'd38);

    // Frozen after done
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      check("hold_x3",  x3_out,     32'd38);
      check("hold_res", io_out_res, 32'd38);
    end
    check("hold_done", {31'b0, done}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
